// File: rtl/fcb_chks_pkg.sv
// Shared definitions for the FCB configuration checksum blocks.
package fcb_chks_pkg;

  localparam logic [1:0] CFGCMD_PRECHKS  = 2'h1;
  localparam logic [1:0] CFGCMD_POSTCHKS = 2'h2;

  // Register stages between the chain tails and the accumulator data operand.
  localparam int PIPE_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT,
    ST_WIN,
    ST_ACC0,
    ST_ACC1,
    ST_CHECK
  } seq_state_t;

endpackage

// File: rtl/fcb_postchks_cnt.sv
// Loadable, saturating word counter with a look-ahead terminal-count flag.
module fcb_postchks_cnt #(
  parameter int W = 16
) (
  input  logic         FCB_CLK,
  input  logic         fcb_reg_rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         hit_next
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] target;
  logic [W-1:0] count_inc;

  // Saturating increment: the counter parks at its maximum instead of wrapping.
  assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;
  // Asserted when the pending increment completes the programmed word count.
  assign hit_next  = (count_inc == target);

  // Count register and latched target; load clears the count for a new sequence.
  always_ff @(posedge FCB_CLK or negedge fcb_reg_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!fcb_reg_rstn) begin
      count  <= '0;
      target <= '0;
    end else if (load) begin
      count  <= '0;
      target <= load_val;
    end else if (inc) begin
      count  <= count_inc;
    end
  end

endmodule

// File: rtl/fcb_postchks_seq.sv
// Post-configuration checksum readback sequencer: steps the chain tails one
// word at a time, strobes the accumulator in step with its readback pipeline
// and reports the match result to the CSR block.
module fcb_postchks_seq
  import fcb_chks_pkg::*;
#(
  parameter int WCNT_W   = 16,
  parameter int PIPE_LAT = fcb_chks_pkg::PIPE_LAT
) (
  input  logic              FCB_CLK,
  input  logic              fcb_reg_rstn,
  input  logic [1:0]        CSR_SEQ_cfgcmd,
  input  logic              CSR_SEQ_start,
  input  logic [WCNT_W-1:0] CSR_SEQ_word_cnt,
  input  logic              CHKS_SEQ_chksum_status,
  output logic              SEQ_CCFF_shift_en,
  output logic              SEQ_CHKS_win_postchs_rdata,
  output logic              SEQ_CHKS_fpostchksum_w0_en,
  output logic              SEQ_CHKS_fpostchksum_w1_en,
  output logic              SEQ_CSR_busy,
  output logic              SEQ_CSR_done,
  output logic              SEQ_CSR_result_valid,
  output logic              SEQ_CSR_result_pass,
  output logic              SEQ_CSR_aborted,
  output logic [WCNT_W-1:0] SEQ_CSR_words_done
);

  // WAIT covers the pipeline stages beyond the first, so WIN lands one cycle
  // before the data operand reaches the accumulator.
  localparam int WAIT_CYC = (PIPE_LAT > 2) ? PIPE_LAT - 2 : 0;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC);

  seq_state_t state, next_state;
  logic [7:0] wait_cnt;
  logic       cmd_ok;
  logic       accept;
  logic       abort;
  logic       abort_q;
  logic       check_done;
  logic       cnt_inc;
  logic       hit_next;

  assign cmd_ok = (CSR_SEQ_cfgcmd == CFGCMD_POSTCHKS);

  fcb_postchks_cnt #(
    .W (WCNT_W)
  ) u_cnt (
    .FCB_CLK      (FCB_CLK),
    .fcb_reg_rstn (fcb_reg_rstn),
    .load         (accept),
    .load_val     (CSR_SEQ_word_cnt),
    .inc          (cnt_inc),
    .count        (SEQ_CSR_words_done),
    .hit_next     (hit_next)
  );

  // Next-state and strobe decode; strobes come straight from the state so a
  // reset removes them without waiting for a clock edge.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    next_state                 = state;
    accept                     = 1'b0;
    abort                      = 1'b0;
    check_done                 = 1'b0;
    cnt_inc                    = 1'b0;
    SEQ_CCFF_shift_en          = 1'b0;
    SEQ_CHKS_win_postchs_rdata = 1'b0;
    SEQ_CHKS_fpostchksum_w0_en = 1'b0;
    SEQ_CHKS_fpostchksum_w1_en = 1'b0;

    if (state != ST_IDLE && !cmd_ok) begin
      // Command withdrawn mid-sequence: drop all strobes and return to IDLE.
      abort      = 1'b1;
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (CSR_SEQ_start && cmd_ok) begin
            accept     = 1'b1;
            next_state = (CSR_SEQ_word_cnt == '0) ? ST_CHECK : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          SEQ_CCFF_shift_en = 1'b1;
          next_state        = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) next_state = ST_WIN;
        end
        ST_WIN: begin
          SEQ_CHKS_win_postchs_rdata = 1'b1;
          next_state                 = ST_ACC0;
        end
        ST_ACC0: begin
          SEQ_CHKS_fpostchksum_w0_en = 1'b1;
          next_state                 = ST_ACC1;
        end
        ST_ACC1: begin
          SEQ_CHKS_fpostchksum_w1_en = 1'b1;
          cnt_inc                    = 1'b1;
          next_state                 = hit_next ? ST_CHECK : ST_SHIFT;
        end
        ST_CHECK: begin
          check_done = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign SEQ_CSR_busy = (state != ST_IDLE);
  // Completion is reported in CHECK, or in the IDLE cycle following an abort.
  assign SEQ_CSR_done = check_done | abort_q;

  // State register, WAIT stage counter and sticky result fields.
  always_ff @(posedge FCB_CLK or negedge fcb_reg_rstn) begin
    if (!fcb_reg_rstn) begin
      state                <= ST_IDLE;
      wait_cnt             <= '0;
      abort_q              <= 1'b0;
      SEQ_CSR_result_valid <= 1'b0;
      SEQ_CSR_result_pass  <= 1'b0;
      SEQ_CSR_aborted      <= 1'b0;
    end else begin
      state    <= next_state;
      abort_q  <= abort;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
      if (accept) begin
        SEQ_CSR_result_valid <= 1'b0;
        SEQ_CSR_result_pass  <= 1'b0;
        SEQ_CSR_aborted      <= 1'b0;
      end else if (abort) begin
        SEQ_CSR_result_valid <= 1'b0;
        SEQ_CSR_result_pass  <= 1'b0;
        SEQ_CSR_aborted      <= 1'b1;
      end else if (check_done) begin
        SEQ_CSR_result_valid <= 1'b1;
        SEQ_CSR_result_pass  <= CHKS_SEQ_chksum_status;
      end
    end
  end

endmodule

// File: tb/tb_fcb_postchks_seq.sv
// Scoreboard bench for the post-checksum sequencer: directed sequences push
// expected strobe events; a negedge monitor pops and compares them.
module tb_fcb_postchks_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    cfgcmd = 2'h0;
  logic          start = 1'b0;
  logic [W-1:0]  word_cnt = '0;
  logic          status;
  logic          shift_en, win, w0, w1, busy, done, valid, pass, aborted;
  logic [W-1:0]  words_done;

  always #5 clk = ~clk;

  fcb_postchks_seq #(.WCNT_W(W), .PIPE_LAT(2)) dut (
    .FCB_CLK                    (clk),
    .fcb_reg_rstn               (rstn),
    .CSR_SEQ_cfgcmd             (cfgcmd),
    .CSR_SEQ_start              (start),
    .CSR_SEQ_word_cnt           (word_cnt),
    .CHKS_SEQ_chksum_status     (status),
    .SEQ_CCFF_shift_en          (shift_en),
    .SEQ_CHKS_win_postchs_rdata (win),
    .SEQ_CHKS_fpostchksum_w0_en (w0),
    .SEQ_CHKS_fpostchksum_w1_en (w1),
    .SEQ_CSR_busy               (busy),
    .SEQ_CSR_done               (done),
    .SEQ_CSR_result_valid       (valid),
    .SEQ_CSR_result_pass        (pass),
    .SEQ_CSR_aborted            (aborted),
    .SEQ_CSR_words_done         (words_done)
  );

  // ---------------- chain-tail and accumulator model ----------------
  logic [31:0] tail_q[$];
  logic [31:0] tail = 32'h0;
  logic [31:0] acc  = 32'h0;
  logic [31:0] prog = 32'h0;
  logic        acc_clr = 1'b0;

  assign status = (acc == prog);

  always @(posedge clk) begin
    if (acc_clr)  acc <= 32'h0;
    else if (w0)  acc <= acc + {16'h0, tail[15:0]};
    else if (w1)  acc <= acc + {16'h0, tail[31:16]};
    if (shift_en && tail_q.size() > 0) tail <= tail_q.pop_front();
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int           cyc;
    logic [4:0]   ev;   // {shift, win, w0, w1, done}
    logic [W-1:0] wd;
  } ev_t;

  ev_t exp_q[$];
  ev_t got;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [4:0] ev, input int wd);
    ev_t e;
    e.cyc = c;
    e.ev  = ev;
    e.wd  = W'(wd);
    exp_q.push_back(e);
  endtask

  // One word occupies five cycles starting with SHIFT at s+1+5k.
  task automatic push_word(input int s, input int k);
    int t;
    t = s + 1 + 5 * k;
    push_ev(t,     5'b10000, k);
    push_ev(t + 2, 5'b01000, k);
    push_ev(t + 3, 5'b00100, k);
    push_ev(t + 4, 5'b00010, k);
  endtask

  // Monitor: every cycle with a strobe or done must match the queue head.
  always @(negedge clk) begin
    if ({shift_en, win, w0, w1, done} != 5'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {27'h0, shift_en, win, w0, w1, done}, 32'h0);
      end else begin
        got = exp_q.pop_front();
        check("event_cycle", cyc, got.cyc);
        check("event_strobes", {27'h0, shift_en, win, w0, w1, done}, {27'h0, got.ev});
        check("event_words_done", {16'h0, words_done}, {16'h0, got.wd});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [1:0] cmd, input int n, input logic clr, output int s);
    @(posedge clk); #1;
    cfgcmd   = cmd;
    word_cnt = W'(n);
    start    = 1'b1;
    acc_clr  = clr;
    s        = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Results are registered at the end of CHECK, so sample one edge after done.
  task automatic check_results(input string name, input logic [2:0] vpa, input int wd);
    @(posedge clk); #1;
    check({name, "_valid_pass_aborted"}, {29'h0, valid, pass, aborted}, {29'h0, vpa});
    check({name, "_words_done"}, {16'h0, words_done}, wd);
    check({name, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  function automatic logic [31:0] out_vec();
    return {7'h0, shift_en, win, w0, w1, busy, done, valid, pass, aborted, words_done};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;

    // Reset state.
    #12;
    check("reset_outputs", out_vec(), 32'h0);
    #10 rstn = 1'b1;

    // Single word, matching checksum: 0x0002 + 0x0001 = 3.
    tail_q.push_back(32'h0001_0002);
    prog = 32'd3;
    do_start(2'h2, 1, 1'b1, s);
    push_word(s, 0);
    push_ev(s + 6, 5'b00001, 1);
    drain("single_drain", 20);
    check_results("single", 3'b110, 1);

    // Three words, checksum programmed one off (sum is 21).
    tail_q.push_back(32'h0001_0002);
    tail_q.push_back(32'h0003_0004);
    tail_q.push_back(32'h0005_0006);
    prog = 32'd22;
    do_start(2'h2, 3, 1'b1, s);
    for (int k = 0; k < 3; k++) push_word(s, k);
    push_ev(s + 16, 5'b00001, 3);
    drain("three_drain", 40);
    check_results("three", 3'b100, 3);

    // Zero words: straight to CHECK, status of the cleared accumulator.
    prog = 32'd0;
    do_start(2'h2, 0, 1'b1, s);
    push_ev(s + 1, 5'b00001, 0);
    drain("zero_drain", 10);
    check_results("zero", 3'b110, 0);

    // Abort: command withdrawn during ACC0 of the second word.
    for (int k = 1; k <= 4; k++) tail_q.push_back(32'(k));
    do_start(2'h2, 4, 1'b1, s);
    push_word(s, 0);
    push_ev(s + 6, 5'b10000, 1);
    push_ev(s + 8, 5'b01000, 1);
    push_ev(s + 10, 5'b00001, 1);
    wait_cyc(s + 9);
    cfgcmd = 2'h0;
    drain("abort_drain", 20);
    repeat (2) @(posedge clk);
    check_results("abort", 3'b001, 1);
    tail_q.delete();

    // Start with the pre-checksum command is ignored; sticky fields remain.
    do_start(2'h1, 3, 1'b0, s);
    check("precmd_busy", {31'h0, busy}, 32'h0);
    repeat (4) @(posedge clk);
    check_results("precmd", 3'b001, 1);

    // Start while busy does not reload the count.
    tail_q.push_back(32'h0000_0001);
    tail_q.push_back(32'h0000_0002);
    prog = 32'd3;
    do_start(2'h2, 2, 1'b1, s);
    push_word(s, 0);
    push_word(s, 1);
    push_ev(s + 11, 5'b00001, 2);
    do_start(2'h2, 5, 1'b0, s);
    drain("restart_drain", 40);
    repeat (10) @(posedge clk);
    check_results("restart", 3'b110, 2);
    tail_q.delete();

    // Asynchronous reset while in WIN.
    tail_q.push_back(32'h0000_0005);
    do_start(2'h2, 3, 1'b1, s);
    push_ev(s + 1, 5'b10000, 0);
    wait_cyc(s + 3);
    #1 rstn = 1'b0;
    #1;
    check("async_reset_outputs", out_vec(), 32'h0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    check("after_reset_busy", {31'h0, busy}, 32'h0);
    repeat (8) @(posedge clk);
    check("after_reset_queue", exp_q.size(), 0);
    tail_q.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
